dmem_arbiter: RTL and testbench

Shares the single data-memory port between the pipeline MEM stage (core) and an external debug/loader requester (dbg). The core owns the port by default with a combinational pass-through. Debug gets the port in registered bursts. While debug owns the port, any core access is stalled. The block sits between the datapath memory outputs and the data memory.

---
 rtl/dmem_arbiter_if.sv | 58 +++++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: groups the core requester, the debug requester and the
// single data-memory port that the arbiter shares between them.
//   slave  - the arbiter's view (requests in, memory port and responses out)
//   master - the surrounding system's view (requesters plus the memory)
interface dmem_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    // Core (pipeline MEM stage) requester
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_din;
    logic [2:0]    core_strb;
    logic [DW-1:0] core_dout;
    logic          core_stall;

    // Debug / loader requester
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_din;
    logic [2:0]    dbg_strb;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_dout;

    // Data-memory port (asynchronous read)
    logic          mem_we;
    logic [AW-1:0] mem_rd_addr;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_din;
    logic [2:0]    mem_strb;
    logic [DW-1:0] mem_dout;

    // Current port owner: 0 = core, 1 = debug
    logic          owner;

    modport slave (
        input  core_req, core_we, core_addr, core_din, core_strb,
        output core_dout, core_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_din, dbg_strb,
        output dbg_gnt, dbg_rvalid, dbg_dout,
        output mem_we, mem_rd_addr, mem_wr_addr, mem_din, mem_strb,
        input  mem_dout,
        output owner
    );

    modport master (
        output core_req, core_we, core_addr, core_din, core_strb,
        input  core_dout, core_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_din, dbg_strb,
        input  dbg_gnt, dbg_rvalid, dbg_dout,
        input  mem_we, mem_rd_addr, mem_wr_addr, mem_din, mem_strb,
        output mem_dout,
        input  owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the pipeline MEM stage
// (default owner, combinational pass-through) and a debug/loader requester
// that is served in registered bursts of up to MAX_BURST accesses.
// Optional feature macro: DMEM_ARB_PREEMPT_EN
//   defined   - debug preempts a continuously busy core after STARVE_LIMIT
//               consecutive blocked cycles.
//   undefined - strict core priority; a core request during a debug burst
//               ends the burst at the next edge.
module dmem_arbiter #(
    parameter int AW           = 7,
    parameter int DW           = 32,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    typedef enum logic {
        S_CORE = 1'b0,
        S_DBG  = 1'b1
    } state_e;

    // burst_cnt must be able to hold MAX_BURST-1 and still work for MAX_BURST = 1
    localparam int            BW         = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0] BURST_ONE  = BW'(1);

    state_e        state_q, state_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic          dbg_rvalid_q, dbg_rvalid_d;
    logic [DW-1:0] dbg_dout_q, dbg_dout_d;

    logic          dbg_gnt_raw;
    logic          core_stall_raw;
    logic          mem_we_raw;
    logic          sel_dbg;
    logic [AW-1:0] mem_addr;

`ifdef DMEM_ARB_PREEMPT_EN
    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
`endif

    // Ownership FSM: next state, burst/starvation counters and raw handshake outputs
    always_comb begin
        // NOTE: every output of this block gets a default before the case;
        // a path that leaves one unassigned would infer a latch.
        state_d        = state_q;
        burst_cnt_d    = burst_cnt_q;
        dbg_gnt_raw    = 1'b0;
        core_stall_raw = 1'b0;
        mem_we_raw     = 1'b0;
`ifdef DMEM_ARB_PREEMPT_EN
        starve_cnt_d   = starve_cnt_q;
`endif
        case (state_q)
            S_CORE: begin
                mem_we_raw = bus.core_req & bus.core_we;
`ifdef DMEM_ARB_PREEMPT_EN
                // Count consecutive cycles in which debug is blocked by the core
                if (bus.dbg_req && bus.core_req) begin
                    if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + STARVE_ONE;
                    end
                end else begin
                    starve_cnt_d = '0;
                end
                if (bus.dbg_req && (!bus.core_req || starve_cnt_q == STARVE_MAX)) begin
                    state_d      = S_DBG;
                    burst_cnt_d  = '0;
                    starve_cnt_d = '0;
                end
`else
                if (bus.dbg_req && !bus.core_req) begin
                    state_d     = S_DBG;
                    burst_cnt_d = '0;
                end
`endif
            end
            S_DBG: begin
                mem_we_raw     = bus.dbg_req & bus.dbg_we;
                dbg_gnt_raw    = bus.dbg_req;
                core_stall_raw = bus.core_req;
                if (bus.dbg_req) begin
                    burst_cnt_d = burst_cnt_q + BURST_ONE;
                end
                // Leave on an idle debug cycle or after the last beat of the burst
                if (!bus.dbg_req || burst_cnt_q == BURST_LAST) begin
                    state_d = S_CORE;
                end
`ifndef DMEM_ARB_PREEMPT_EN
                // Strict priority: a core request hands the port back after this beat
                if (bus.core_req) begin
                    state_d = S_CORE;
                end
`endif
            end
            default: state_d = S_CORE;
        endcase
    end

    // Debug read capture: latch memory data on a granted debug read, else hold
    always_comb begin
        dbg_rvalid_d = dbg_gnt_raw & ~bus.dbg_we;
        dbg_dout_d   = dbg_rvalid_d ? bus.mem_dout : dbg_dout_q;
    end

    // State, counters and registered debug read response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_CORE;
            burst_cnt_q  <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_dout_q   <= '0;
`ifdef DMEM_ARB_PREEMPT_EN
            starve_cnt_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of its _d input, independent of statement order.
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_dout_q   <= dbg_dout_d;
`ifdef DMEM_ARB_PREEMPT_EN
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    // Memory port steering: the owner's request goes straight to the memory
    assign sel_dbg         = (state_q == S_DBG);
    assign mem_addr        = sel_dbg ? bus.dbg_addr : bus.core_addr;
    assign bus.mem_rd_addr = mem_addr;
    assign bus.mem_wr_addr = mem_addr;
    assign bus.mem_din     = sel_dbg ? bus.dbg_din  : bus.core_din;
    assign bus.mem_strb    = sel_dbg ? bus.dbg_strb : bus.core_strb;

    // Handshake outputs are held low for as long as reset is asserted,
    // so a write cannot slip into memory while the block is being reset
    assign bus.mem_we     = rst & mem_we_raw;
    assign bus.dbg_gnt    = rst & dbg_gnt_raw;
    assign bus.core_stall = rst & core_stall_raw;

    assign bus.core_dout  = bus.mem_dout;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.dbg_dout   = dbg_dout_q;
    assign bus.owner      = sel_dbg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a strobe-aware
// data-memory model. Expected memory writes and debug read data are queued
// by the stimulus and consumed by a monitor whenever the DUT writes memory
// or raises dbg_rvalid; cycle-exact handshake values are checked inline.
module tb_dmem_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    strb;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    int n_vec = 0;
    int n_err = 0;

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_rd[$];

    logic [DW-1:0] mem_model [128];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(8), .STARVE_LIMIT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_dout = mem_model[bus.mem_rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Data memory: pattern-initialised, strobe-aware synchronous write
    initial begin : mem_proc
        logic [31:0] w;
        logic [2:0]  s;
        for (int i = 0; i < 128; i++) mem_model[i] = 32'hA500_0000 | 32'(i);
        forever begin
            @(posedge clk);
            if (rst && bus.mem_we) begin
                w = mem_model[bus.mem_wr_addr];
                s = bus.mem_strb;
                if (s[2])      w[8*s[1:0] +: 8] = bus.mem_din[7:0];
                else if (s[0]) w[16*s[1] +: 16] = bus.mem_din[15:0];
                else           w = bus.mem_din;
                mem_model[bus.mem_wr_addr] = w;
            end
        end
    end

    // Monitor: consume expected writes and read responses as the DUT presents them
    always @(negedge clk) begin : monitor
        wr_t           e;
        logic [DW-1:0] d;
        if (rst) begin
            if (bus.mem_we) begin
                if (exp_wr.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got write to 0x%0h, expected none at %0t",
                             bus.mem_wr_addr, $time);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(bus.mem_wr_addr), 32'(e.addr));
                    check("wr_data", bus.mem_din, e.data);
                    check("wr_strb", 32'(bus.mem_strb), 32'(e.strb));
                end
            end
            if (bus.dbg_rvalid) begin
                if (exp_rd.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rvalid: got dbg_dout 0x%08h, expected no response at %0t",
                             bus.dbg_dout, $time);
                end else begin
                    d = exp_rd.pop_front();
                    check("dbg_dout", bus.dbg_dout, d);
                end
            end
        end
    end

    task automatic set_core(input logic req, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] din, input logic [2:0] strb);
        bus.core_req  = req;
        bus.core_we   = we;
        bus.core_addr = addr;
        bus.core_din  = din;
        bus.core_strb = strb;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] din, input logic [2:0] strb);
        bus.dbg_req  = req;
        bus.dbg_we   = we;
        bus.dbg_addr = addr;
        bus.dbg_din  = din;
        bus.dbg_strb = strb;
    endtask

    task automatic push_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [2:0] strb);
        wr_t e;
        e.addr = addr;
        e.data = data;
        e.strb = strb;
        exp_wr.push_back(e);
    endtask

    // Start a new cycle: inputs are changed 1 time unit after the rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the stimulus never waits on the DUT, but bound the run anyway
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic gnt_e;
        logic own_e;
        rst = 1'b1;
        set_core(1'b1, 1'b1, 7'd5, 32'hFFFF_FFFF, 3'b000);
        set_dbg(1'b0, 1'b0, '0, '0, 3'b000);
        #3 rst = 1'b0;

        // ---------------- reset state (core store pending, must be masked)
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_owner",      32'(bus.owner),      32'd0);
        check("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        check("rst_dbg_dout",   bus.dbg_dout,        32'd0);
        check("rst_dbg_gnt",    32'(bus.dbg_gnt),    32'd0);
        check("rst_core_stall", 32'(bus.core_stall), 32'd0);
        check("rst_mem_we",     32'(bus.mem_we),     32'd0);
        #2 rst = 1'b1;
        set_core(1'b0, 1'b0, '0, '0, 3'b000);

        // ---------------- core only: word, byte, half stores and loads
        next_cycle();
        set_core(1'b1, 1'b1, 7'd5, 32'hDEAD_BEEF, 3'b000);
        push_wr(7'd5, 32'hDEAD_BEEF, 3'b000);
        @(negedge clk);
        check("core_st_we",    32'(bus.mem_we),     32'd1);
        check("core_st_stall", 32'(bus.core_stall), 32'd0);
        next_cycle();
        set_core(1'b1, 1'b0, 7'd5, '0, 3'b000);
        @(negedge clk);
        check("core_ld_dout",  bus.core_dout,       32'hDEAD_BEEF);
        check("core_ld_we",    32'(bus.mem_we),     32'd0);
        check("core_ld_stall", 32'(bus.core_stall), 32'd0);
        check("core_ld_owner", 32'(bus.owner),      32'd0);
        next_cycle();
        set_core(1'b1, 1'b1, 7'd5, 32'h0000_00AA, 3'b110);
        push_wr(7'd5, 32'h0000_00AA, 3'b110);
        next_cycle();
        set_core(1'b1, 1'b1, 7'd5, 32'h0000_1234, 3'b011);
        push_wr(7'd5, 32'h0000_1234, 3'b011);
        next_cycle();
        set_core(1'b1, 1'b0, 7'd5, '0, 3'b000);
        @(negedge clk);
        check("core_strb_dout", bus.core_dout, 32'h1234_BEEF);
        next_cycle();
        set_core(1'b0, 1'b0, '0, '0, 3'b000);

        // ---------------- debug write then read, core idle
        next_cycle();
        set_dbg(1'b1, 1'b1, 7'd9, 32'h1234_5678, 3'b000);
        @(negedge clk);
        check("dbg_c0_gnt",   32'(bus.dbg_gnt), 32'd0);
        check("dbg_c0_owner", 32'(bus.owner),   32'd0);
        next_cycle();
        push_wr(7'd9, 32'h1234_5678, 3'b000);
        @(negedge clk);
        check("dbg_c1_gnt",   32'(bus.dbg_gnt), 32'd1);
        check("dbg_c1_owner", 32'(bus.owner),   32'd1);
        next_cycle();
        set_dbg(1'b1, 1'b0, 7'd9, '0, 3'b000);
        exp_rd.push_back(32'h1234_5678);
        @(negedge clk);
        check("dbg_c2_gnt", 32'(bus.dbg_gnt), 32'd1);
        check("dbg_c2_we",  32'(bus.mem_we),  32'd0);
        next_cycle();
        set_dbg(1'b0, 1'b0, '0, '0, 3'b000);
        @(negedge clk);
        check("dbg_c3_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        check("dbg_c3_gnt",    32'(bus.dbg_gnt),    32'd0);
        check("dbg_c3_owner",  32'(bus.owner),      32'd1);
        next_cycle();
        @(negedge clk);
        check("dbg_c4_owner",  32'(bus.owner),      32'd0);
        check("dbg_c4_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        check("dbg_c4_hold",   bus.dbg_dout,        32'h1234_5678);

        // ---------------- burst limit: dbg_req held 20 cycles, core idle
        for (int c = 0; c < 22; c++) begin
            next_cycle();
            if (c < 20) set_dbg(1'b1, 1'b0, 7'(16 + c), '0, 3'b000);
            else        set_dbg(1'b0, 1'b0, '0, '0, 3'b000);
            gnt_e = (c >= 1 && c <= 8) || (c >= 10 && c <= 17) || (c == 19);
            own_e = gnt_e || (c == 20);
            if (gnt_e) exp_rd.push_back(32'hA500_0000 | 32'(16 + c));
            @(negedge clk);
            check("burst_gnt",   32'(bus.dbg_gnt), 32'(gnt_e));
            check("burst_owner", 32'(bus.owner),   32'(own_e));
        end

`ifdef DMEM_ARB_PREEMPT_EN
        // ---------------- preemption: core and debug both held busy
        for (int c = 0; c < 19; c++) begin
            next_cycle();
            set_core(1'b1, 1'b0, 7'd5, '0, 3'b000);
            set_dbg(1'b1, 1'b0, 7'd40, '0, 3'b000);
            gnt_e = (c >= 5 && c <= 12) || (c == 18);
            if (gnt_e) exp_rd.push_back(32'hA500_0028);
            @(negedge clk);
            check("pre_gnt",   32'(bus.dbg_gnt),    32'(gnt_e));
            check("pre_stall", 32'(bus.core_stall), 32'(gnt_e));
            check("pre_owner", 32'(bus.owner),      32'(gnt_e));
            if (c == 13) check("pre_core_dout", bus.core_dout, 32'h1234_BEEF);
        end
        next_cycle();
        set_core(1'b0, 1'b0, '0, '0, 3'b000);
        set_dbg(1'b0, 1'b0, '0, '0, 3'b000);
        @(negedge clk);
        check("pre_end_owner", 32'(bus.owner),      32'd1);
        check("pre_end_stall", 32'(bus.core_stall), 32'd0);
        next_cycle();
        @(negedge clk);
        check("pre_back_owner", 32'(bus.owner), 32'd0);
`else
        // ---------------- strict priority: busy core blocks debug indefinitely
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            set_core(1'b1, 1'b0, 7'd5, '0, 3'b000);
            set_dbg(1'b1, 1'b0, 7'd41, '0, 3'b000);
            @(negedge clk);
            check("strict_gnt",   32'(bus.dbg_gnt),    32'd0);
            check("strict_stall", 32'(bus.core_stall), 32'd0);
            check("strict_owner", 32'(bus.owner),      32'd0);
            if (c == 2) check("strict_core_dout", bus.core_dout, 32'h1234_BEEF);
        end
        next_cycle();
        set_core(1'b0, 1'b0, '0, '0, 3'b000);
        @(negedge clk);
        check("strict_drop_gnt", 32'(bus.dbg_gnt), 32'd0);
        next_cycle();
        exp_rd.push_back(32'hA500_0029);
        @(negedge clk);
        check("strict_grant_gnt",   32'(bus.dbg_gnt),    32'd1);
        check("strict_grant_owner", 32'(bus.owner),      32'd1);
        check("strict_grant_stall", 32'(bus.core_stall), 32'd0);
        next_cycle();
        set_core(1'b1, 1'b0, 7'd5, '0, 3'b000);
        exp_rd.push_back(32'hA500_0029);
        @(negedge clk);
        check("strict_rise_gnt",   32'(bus.dbg_gnt),    32'd1);
        check("strict_rise_stall", 32'(bus.core_stall), 32'd1);
        next_cycle();
        @(negedge clk);
        check("strict_back_gnt",   32'(bus.dbg_gnt),    32'd0);
        check("strict_back_stall", 32'(bus.core_stall), 32'd0);
        check("strict_back_owner", 32'(bus.owner),      32'd0);
        check("strict_back_dout",  bus.core_dout,       32'h1234_BEEF);
        next_cycle();
        set_core(1'b0, 1'b0, '0, '0, 3'b000);
        set_dbg(1'b0, 1'b0, '0, '0, 3'b000);
        @(negedge clk);
        check("strict_idle_owner", 32'(bus.owner), 32'd0);
`endif

        // ---------------- reset pulse during the 3rd beat of a write burst
        next_cycle();
        set_dbg(1'b1, 1'b1, 7'd50, 32'h1111_1111, 3'b000);
        @(negedge clk);
        check("rb_c0_owner", 32'(bus.owner), 32'd0);
        next_cycle();
        push_wr(7'd50, 32'h1111_1111, 3'b000);
        @(negedge clk);
        check("rb_c1_gnt", 32'(bus.dbg_gnt), 32'd1);
        next_cycle();
        set_dbg(1'b1, 1'b1, 7'd51, 32'h2222_2222, 3'b000);
        push_wr(7'd51, 32'h2222_2222, 3'b000);
        @(negedge clk);
        check("rb_c2_gnt", 32'(bus.dbg_gnt), 32'd1);
        next_cycle();
        set_dbg(1'b1, 1'b1, 7'd52, 32'h3333_3333, 3'b000);
        set_core(1'b1, 1'b0, 7'd5, '0, 3'b000);
        #1;
        check("rb_pre_we",    32'(bus.mem_we),     32'd1);
        check("rb_pre_stall", 32'(bus.core_stall), 32'd1);
        rst = 1'b0;
        #1;
        check("rb_owner",  32'(bus.owner),      32'd0);
        check("rb_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        check("rb_gnt",    32'(bus.dbg_gnt),    32'd0);
        check("rb_we",     32'(bus.mem_we),     32'd0);
        check("rb_stall",  32'(bus.core_stall), 32'd0);
        check("rb_dout",   bus.dbg_dout,        32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        set_core(1'b0, 1'b0, '0, '0, 3'b000);
        set_dbg(1'b0, 1'b0, '0, '0, 3'b000);
        next_cycle();
        set_core(1'b1, 1'b0, 7'd52, '0, 3'b000);
        @(negedge clk);
        check("rb_after_dout",  bus.core_dout,       32'hA500_0034);
        check("rb_after_owner", 32'(bus.owner),      32'd0);
        check("rb_after_stall", 32'(bus.core_stall), 32'd0);
        next_cycle();
        set_core(1'b0, 1'b0, '0, '0, 3'b000);
        set_dbg(1'b1, 1'b0, 7'd51, '0, 3'b000);
        @(negedge clk);
        check("rb_reissue_c0_gnt", 32'(bus.dbg_gnt), 32'd0);
        next_cycle();
        exp_rd.push_back(32'h2222_2222);
        @(negedge clk);
        check("rb_reissue_c1_gnt", 32'(bus.dbg_gnt), 32'd1);
        next_cycle();
        set_dbg(1'b0, 1'b0, '0, '0, 3'b000);
        @(negedge clk);
        check("rb_reissue_c2_owner", 32'(bus.owner), 32'd1);
        next_cycle();
        @(negedge clk);
        check("rb_reissue_c3_owner", 32'(bus.owner), 32'd0);

        // ---------------- drain and confirm every expected response was seen
        repeat (3) next_cycle();
        check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
